spi_ram_burst: RTL



---
 rtl/spi_ram_burst_if.sv | 32 +++
 rtl/spi_ram_burst.sv | 108 ++++++++++
 2 files changed

// File: rtl/spi_ram_burst_if.sv
// spi_ram_burst_if: command/response bundle between the SPI slave and its RAM.
//   din      - command frame {cmd[1:0], payload[DATA_W-1:0]}
//   rx_valid - din valid this cycle
//   dout     - read data
//   tx_valid - one-cycle pulse per read
//   addr_err - sticky out-of-range flag for the last address command
// Modports: master (SPI slave side), slave (RAM side).
interface spi_ram_burst_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              addr_err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  addr_err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output addr_err
    );
endinterface

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: parametrised single-port RAM driven by SPI command frames.
//   cmd 00 set write address, 01 write data, 10 set read address, 11 read data.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - spi_ram_burst_if.slave (din, rx_valid in; dout, tx_valid, addr_err out)
// Optional feature: define RAM_AUTO_INC_EN to post-increment wr_addr after each
// write and rd_addr after each read, wrapping at MEM_DEPTH.
module spi_ram_burst #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_ram_burst_if.slave   bus
);
    localparam int unsigned CMP_W = ADDR_W + 1;

    localparam logic [1:0] CMD_SET_WR = 2'b00;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_SET_RD = 2'b10;
    localparam logic [1:0] CMD_READ   = 2'b11;

    logic [1:0]        cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr_in;
    logic              addr_ok;

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] dout_q;
    logic              tx_valid_q;
    logic              addr_err_q;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Frame decode; upper payload bits are ignored for address commands.
    assign cmd     = bus.din[DATA_W+1:DATA_W];
    assign payload = bus.din[DATA_W-1:0];
    assign addr_in = payload[ADDR_W-1:0];
    // Extra bit lets MEM_DEPTH == 2**ADDR_W be represented in the compare.
    assign addr_ok = ({1'b0, addr_in} < CMP_W'(MEM_DEPTH));

`ifdef RAM_AUTO_INC_EN
    // Wrap against MEM_DEPTH, not the natural 2**ADDR_W rollover.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction
`endif

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (bus.rx_valid && (cmd == CMD_WRITE)) begin
            mem[wr_addr] <= payload;
        end
    end

    // Address registers, read data and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            if (bus.rx_valid) begin
                case (cmd)
                    CMD_SET_WR: begin
                        if (addr_ok) begin
                            wr_addr    <= addr_in;
                            addr_err_q <= 1'b0;
                        end else begin
                            addr_err_q <= 1'b1;
                        end
                    end
                    CMD_WRITE: begin
`ifdef RAM_AUTO_INC_EN
                        wr_addr <= next_addr(wr_addr);
`endif
                    end
                    CMD_SET_RD: begin
                        if (addr_ok) begin
                            rd_addr    <= addr_in;
                            addr_err_q <= 1'b0;
                        end else begin
                            addr_err_q <= 1'b1;
                        end
                    end
                    CMD_READ: begin
                        dout_q     <= mem[rd_addr];
                        tx_valid_q <= 1'b1;
`ifdef RAM_AUTO_INC_EN
                        rd_addr    <= next_addr(rd_addr);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.addr_err = addr_err_q;
endmodule
